// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The 7-segment table is only used when the design is built with BCD_SEG_EN.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DEFAULT_W      = 8;
    localparam int DEFAULT_DIGITS = 3;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between the converter and its user.
// The seg bundle exists only when BCD_SEG_EN is defined.
interface bin_to_bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int DIGITS = DEFAULT_DIGITS
);

    logic                  start;
    logic [W-1:0]          bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_SEG_EN
    logic [7*DIGITS-1:0]   seg;

    modport master (output start, output bin_in,
                    input busy, input done, input bcd, input seg);
    modport slave  (input start, input bin_in,
                    output busy, output done, output bcd, output seg);
`else
    modport master (output start, output bin_in,
                    input busy, input done, input bcd);
    modport slave  (input start, input bin_in,
                    output busy, output done, output bcd);
`endif

endinterface

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: digits of 5 or more get 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock.
// Define BCD_SEG_EN to add registered 7-segment outputs for every digit.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input logic            clk,
    input logic            rst,
    bin_to_bcd_seq_if.slave bus
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int BCD_W = 4 * DIGITS;

    state_t              state;
    state_t              next_state;
    logic [W-1:0]        shreg;
    logic [BCD_W-1:0]    scratch;
    logic [BCD_W-1:0]    adjusted;
    logic [BCD_W-1:0]    scratch_shifted;
    logic [CNT_W-1:0]    cnt;
    logic [BCD_W-1:0]    bcd_q;
    logic                last_shift;
    logic                busy;
    logic                done;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adjust
        bcd_add3 u_add3 (
            .digit    (scratch[4*i +: 4]),
            .adjusted (adjusted[4*i +: 4])
        );
    end

    assign scratch_shifted = {adjusted[BCD_W-2:0], shreg[W-1]};
    assign last_shift      = (state == SHIFT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SHIFT;
            SHIFT:   if (last_shift) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy/done decode straight from the state register, so start never reaches them combinationally
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // The result register loads on the final shift so it is valid in the same cycle done rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(W);
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[W-2:0], 1'b0};
                    scratch <= scratch_shifted;
                    cnt     <= cnt - CNT_W'(1);
                    if (last_shift) begin
                        bcd_q <= scratch_shifted;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.bcd  = bcd_q;

`ifdef BCD_SEG_EN
    logic [7*DIGITS-1:0] seg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= {DIGITS{SEG_0}};
        end else if (last_shift) begin
            for (int i = 0; i < DIGITS; i++) begin
                seg_q[7*i +: 7] <= seg_encode(scratch_shifted[4*i +: 4]);
            end
        end
    end

    assign bus.seg = seg_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected values queued at start, compared on done.
// Also exercises the seg outputs when compiled with BCD_SEG_EN.
module tb_bin_to_bcd_seq;

    localparam int W      = 8;
    localparam int DIGITS = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_q[$];
    logic prev_done;
    int   lat;

    bin_to_bcd_seq_if #(.W(W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] bcd_of(input int value);
        logic [4*DIGITS-1:0] r;
        int t;
        r = '0;
        t = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

`ifdef BCD_SEG_EN
    function automatic logic [7*DIGITS-1:0] seg_of(input int value);
        logic [6:0] seg_tab [10];
        logic [7*DIGITS-1:0] r;
        int t;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        r = '0;
        t = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = seg_tab[t % 10];
            t = t / 10;
        end
        return r;
    endfunction
`endif

    // Scoreboard consumer: every done pulse must match the oldest queued conversion
    always @(negedge clk) begin
        int v;
        if (!rst && bus.done) begin
            check_output("done_width", {31'b0, prev_done}, 32'd0);
            check_output("busy_at_done", {31'b0, bus.busy}, 32'd1);
            check_output("queue_nonempty_at_done", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                check_output($sformatf("bcd_%0d", v), 32'(bus.bcd), 32'(bcd_of(v)));
`ifdef BCD_SEG_EN
                check_output($sformatf("seg_%0d", v), 32'(bus.seg), 32'(seg_of(v)));
`endif
            end
        end
        prev_done = bus.done;
    end

    task automatic wait_done(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cycles++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("done_seen", {31'b0, seen}, 32'd1);
    endtask

    // Drives one start in an IDLE cycle; with hold set, start stays high and bin_in is scrambled
    task automatic apply_stimulus(input int value, input bit hold, output int cycles);
        bit seen;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = value[W-1:0];
        exp_q.push_back(value);
        @(posedge clk);
        #1;
        check_output("busy_after_start", {31'b0, bus.busy}, 32'd1);
        if (!hold) bus.start = 1'b0;
        seen   = 1'b0;
        cycles = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            cycles++;
            if (hold) bus.bin_in = W'($urandom);
        end
        check_output("done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        clk        = 1'b0;
        rst        = 1'b1;
        checks     = 0;
        errors     = 0;
        prev_done  = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", {31'b0, bus.busy}, 32'd0);
        check_output("reset_done", {31'b0, bus.done}, 32'd0);
        check_output("reset_bcd", 32'(bus.bcd), 32'd0);
`ifdef BCD_SEG_EN
        check_output("reset_seg", 32'(bus.seg), 32'(seg_of(0)));
`endif
        rst = 1'b0;

        apply_stimulus(99, 1'b0, lat);
        check_output("latency_99", 32'(lat), 32'(W + 1));

        // Abort 255 after four shifts; no result may ever appear for it
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 8'd255;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("abort_busy", {31'b0, bus.busy}, 32'd0);
        check_output("abort_done", {31'b0, bus.done}, 32'd0);
        check_output("abort_bcd", 32'(bus.bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(7, 1'b0, lat);

        apply_stimulus(0, 1'b0, lat);
        check_output("latency_0", 32'(lat), 32'(W + 1));
        apply_stimulus(255, 1'b0, lat);
        check_output("latency_255", 32'(lat), 32'(W + 1));
        apply_stimulus(100, 1'b0, lat);
        apply_stimulus(99, 1'b0, lat);

        for (int v = 0; v < 256; v++) begin
            apply_stimulus(v, 1'b0, lat);
        end

        // start held high: only the captured value converts, next accept waits for IDLE
        apply_stimulus(200, 1'b1, lat);
        check_output("latency_hold", 32'(lat), 32'(W + 1));
        @(negedge clk);
        check_output("idle_gap_busy", {31'b0, bus.busy}, 32'd0);
        bus.bin_in = 8'd42;
        exp_q.push_back(42);
        @(posedge clk);
        #1;
        check_output("hold_reaccept_busy", {31'b0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_done(cyc);

        apply_stimulus(13 * 11, 1'b0, lat);

        repeat (3) @(negedge clk);
        check_output("pending_results", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
